// File: rtl/recv_pkg.sv
// Shared types, sizes and byte-lane mapping for the serial word receiver.
package recv_pkg;

  localparam int unsigned DATA_BITS      = 8;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned WORD_BITS      = DATA_BITS * BYTES_PER_WORD;
  localparam int unsigned IDX_W          = $clog2(BYTES_PER_WORD);
  localparam int unsigned BIT_W          = $clog2(DATA_BITS);
  localparam int unsigned LSB_W          = $clog2(WORD_BITS);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  // Byte index 0 lands in the most significant lane, index 3 in the least.
  function automatic logic [LSB_W-1:0] lane_lsb(input logic [IDX_W-1:0] idx);
    return LSB_W'((BYTES_PER_WORD - 1 - 32'(idx)) * DATA_BITS);
  endfunction

endpackage

// File: rtl/recv_byte.sv
// 8N1 byte recovery: input synchronizer, byte FSM, tick/bit counters, shift register.
module recv_byte
  import recv_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 recv_clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] byte_o,
  output logic                 byte_vld,
  output logic                 stop_err,
  output logic                 idle,
  output logic                 start_det
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0]    TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0]    TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic                 rxd_meta;
  logic                 rxd_s;
  logic                 rxd_prev;
  logic                 fall;
  state_t               state;
  state_t               state_d;
  logic [TW-1:0]        tick;
  logic [TW-1:0]        tick_d;
  logic [BIT_W-1:0]     bit_cnt;
  logic [BIT_W-1:0]     bit_d;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_d;

  // Two-flop synchronizer plus one delay stage for falling-edge detection; idles high.
  always_ff @(posedge recv_clk or negedge rst) begin
    if (!rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
      rxd_prev <= rxd_s;
    end
  end

  assign fall = rxd_prev & ~rxd_s;

  // State, counters and shift register.
  always_ff @(posedge recv_clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_d;
      tick    <= tick_d;
      bit_cnt <= bit_d;
      shreg   <= shreg_d;
    end
  end

  // Next-state and sample decisions; byte_vld/stop_err fire in the stop-sample cycle.
  always_comb begin
    state_d   = state;
    tick_d    = tick + 1'b1;
    bit_d     = bit_cnt;
    shreg_d   = shreg;
    byte_vld  = 1'b0;
    stop_err  = 1'b0;
    start_det = 1'b0;
    unique case (state)
      IDLE: begin
        tick_d = '0;
        if (fall) begin
          state_d   = START;
          start_det = 1'b1;
        end
      end
      START: begin
        if (tick == TICK_HALF) begin
          tick_d = '0;
          bit_d  = '0;
          state_d = rxd_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick == TICK_LAST) begin
          tick_d  = '0;
          shreg_d = {rxd_s, shreg[DATA_BITS-1:1]};
          bit_d   = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) state_d = STOP;
        end
      end
      STOP: begin
        if (tick == TICK_LAST) begin
          tick_d = '0;
          if (rxd_s) begin
            byte_vld = 1'b1;
            state_d  = IDLE;
          end else begin
            stop_err = 1'b1;
            state_d  = BREAK;
          end
        end
      end
      BREAK: begin
        tick_d = '0;
        if (rxd_s) state_d = IDLE;
      end
      default: begin
        tick_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign byte_o = shreg;
  assign idle   = (state == IDLE);

endmodule

// File: rtl/recv_word.sv
// Serial word receiver: assembles four 8N1 bytes (MSB lane first) into a 32-bit word.
module recv_word
  import recv_pkg::*;
#(
  parameter int unsigned OVERSAMPLE   = 16,
  parameter int unsigned TIMEOUT_BITS = 16
) (
  input  logic                 recv_clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [WORD_BITS-1:0] data_r,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 timeout,
  output logic                 busy
);

  localparam int unsigned      GAP_LIMIT = TIMEOUT_BITS * OVERSAMPLE;
  localparam int unsigned      GAP_W     = $clog2(GAP_LIMIT + 1);
  localparam logic [GAP_W-1:0] GAP_END   = GAP_W'(GAP_LIMIT);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BYTES_PER_WORD - 1);

  logic [DATA_BITS-1:0] byte_o;
  logic                 byte_vld;
  logic                 stop_err;
  logic                 idle;
  logic                 start_det;
  logic [IDX_W-1:0]     idx;
  logic [WORD_BITS-1:0] word_q;
  logic [WORD_BITS-1:0] word_next;
  logic [GAP_W-1:0]     gap;
  logic                 gap_run;
  logic                 timeout_hit;

  recv_byte #(
    .OVERSAMPLE(OVERSAMPLE)
  ) u_byte (
    .recv_clk  (recv_clk),
    .rst       (rst),
    .rxd       (rxd),
    .byte_o    (byte_o),
    .byte_vld  (byte_vld),
    .stop_err  (stop_err),
    .idle      (idle),
    .start_det (start_det)
  );

  // Partial word with the incoming byte dropped into its lane.
  always_comb begin
    word_next = word_q;
    word_next[lane_lsb(idx) +: DATA_BITS] = byte_o;
  end

  // A start edge in the same cycle as the limit suppresses the timeout.
  assign gap_run     = idle && (idx != '0) && !start_det;
  assign timeout_hit = gap_run && (gap == GAP_END);

  // Inter-byte gap counter, active only while a partial word waits in IDLE.
  always_ff @(posedge recv_clk or negedge rst) begin
    if (!rst) begin
      gap <= '0;
    end else if (!gap_run || timeout_hit) begin
      gap <= '0;
    end else begin
      gap <= gap + 1'b1;
    end
  end

  // Word assembler and registered one-cycle status pulses.
  always_ff @(posedge recv_clk or negedge rst) begin
    if (!rst) begin
      idx       <= '0;
      word_q    <= '0;
      data_r    <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
      timeout   <= 1'b0;
      if (stop_err) begin
        idx       <= '0;
        word_q    <= '0;
        frame_err <= 1'b1;
      end else if (byte_vld) begin
        if (idx == IDX_LAST) begin
          data_r <= word_next;
          valid  <= 1'b1;
          idx    <= '0;
          word_q <= '0;
        end else begin
          word_q <= word_next;
          idx    <= idx + 1'b1;
        end
      end else if (timeout_hit) begin
        idx     <= '0;
        word_q  <= '0;
        timeout <= 1'b1;
      end
    end
  end

  assign busy = !idle || (idx != '0);

endmodule
